led_frame_loader: RTL and testbench

- Sits between uart_rx and the LED panel scan driver. Parses framed UART commands into a double-buffered 16x8 frame store and a 3-bit colour register.
- The scan driver reads the display buffer through a combinational column port.
- Buffers swap only at a frame boundary signalled by the driver, so a partially loaded frame is never shown.

---
 rtl/led_panel_pkg.sv | 21 ++
 rtl/led_frame_dbuf.sv | 62 ++++++
 rtl/led_frame_loader.sv | 165 ++++++++++++++++
 tb/tb_led_frame_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared constants and parser state type for the LED panel frame loader.
// Imported by the frame loader top and its double-buffer store.
package led_panel_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_LOAD   = 8'h01;
    localparam logic [7:0] CMD_COLOUR = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;

    localparam int FRAME_COLS = 16;
    localparam int ROW_BITS   = 8;
    localparam int COL_BITS   = $clog2(FRAME_COLS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } parser_state_t;

endpackage

// File: rtl/led_frame_dbuf.sv
// Double-buffered 16x8 frame store: back-side write/clear, swap on request,
// combinational read of the display side.
module led_frame_dbuf
    import led_panel_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [COL_BITS-1:0] wr_addr,
    input  logic [ROW_BITS-1:0] wr_data,
    input  logic                clear,
    input  logic                swap,
    input  logic [COL_BITS-1:0] rd_col,
    output logic [ROW_BITS-1:0] rd_data
);

    logic disp_sel_reg;
    logic [FRAME_COLS-1:0][ROW_BITS-1:0] buf0_flat;
    logic [FRAME_COLS-1:0][ROW_BITS-1:0] buf1_flat;

    // The back buffer is whichever one is not being displayed.
    logic back0_sel;
    assign back0_sel = disp_sel_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_sel_reg <= 1'b0;
        end else if (swap) begin
            disp_sel_reg <= ~disp_sel_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FRAME_COLS; gi++) begin : g_col
            logic [ROW_BITS-1:0] col0_reg;
            logic [ROW_BITS-1:0] col1_reg;
            logic                hit;

            assign hit = wr_en && (wr_addr == COL_BITS'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    col0_reg <= '0;
                    col1_reg <= '0;
                end else if (back0_sel) begin
                    if (clear)    col0_reg <= '0;
                    else if (hit) col0_reg <= wr_data;
                end else begin
                    if (clear)    col1_reg <= '0;
                    else if (hit) col1_reg <= wr_data;
                end
            end

            assign buf0_flat[gi] = col0_reg;
            assign buf1_flat[gi] = col1_reg;
        end
    endgenerate

    assign rd_data = disp_sel_reg ? buf1_flat[rd_col] : buf0_flat[rd_col];

endmodule

// File: rtl/led_frame_loader.sv
// UART packet parser feeding a double-buffered LED frame store and colour
// register; frames become visible only at a driver frame boundary.
module led_frame_loader #(
    parameter logic [7:0] SYNC_BYTE    = led_panel_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 1024,
    parameter logic [2:0] RGB_RESET    = 3'b101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_dv,
    input  logic       frame_sync,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_data,
    output logic [2:0] rgb,
    output logic       frame_pending,
    output logic       busy,
    output logic       err
);

    import led_panel_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    parser_state_t state_reg, state_next;
    logic [COL_BITS-1:0] idx_reg, idx_next;
    logic [7:0]          cmd_reg, cmd_next;
    logic [7:0]          chk_reg, chk_next;
    logic [2:0]          colour_reg, colour_next;
    logic [TW-1:0]       tmo_cnt_reg, tmo_cnt_next;
    logic [2:0]          rgb_reg;
    logic                pending_reg, pending_next;
    logic                err_reg, err_next;

    logic wr_en, clear, swap, pending_clr;
    logic commit_load, commit_colour;
    logic timeout, last_payload;

    assign timeout      = (state_reg != IDLE) && !rx_dv && (tmo_cnt_reg == TMO_LAST);
    assign last_payload = (cmd_reg == CMD_LOAD) ? (idx_reg == COL_BITS'(FRAME_COLS - 1)) : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cmd_reg     <= '0;
            chk_reg     <= '0;
            colour_reg  <= '0;
            tmo_cnt_reg <= '0;
            rgb_reg     <= RGB_RESET;
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cmd_reg     <= cmd_next;
            chk_reg     <= chk_next;
            colour_reg  <= colour_next;
            tmo_cnt_reg <= tmo_cnt_next;
            pending_reg <= pending_next;
            err_reg     <= err_next;
            if (commit_colour) rgb_reg <= colour_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cmd_next      = cmd_reg;
        chk_next      = chk_reg;
        colour_next   = colour_reg;
        err_next      = 1'b0;
        wr_en         = 1'b0;
        clear         = 1'b0;
        pending_clr   = 1'b0;
        commit_load   = 1'b0;
        commit_colour = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_dv && rx_data == SYNC_BYTE) state_next = CMD;
            end
            CMD: begin
                if (rx_dv) begin
                    cmd_next = rx_data;
                    chk_next = rx_data;
                    idx_next = '0;
                    case (rx_data)
                        CMD_LOAD: begin
                            state_next  = PAYLOAD;
                            pending_clr = 1'b1;
                        end
                        CMD_COLOUR: state_next = PAYLOAD;
                        CMD_CLEAR:  state_next = CHECK;
                        default: begin
                            state_next = IDLE;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            PAYLOAD: begin
                if (rx_dv) begin
                    chk_next = chk_reg ^ rx_data;
                    idx_next = idx_reg + 1'b1;
                    if (cmd_reg == CMD_LOAD) wr_en = 1'b1;
                    else                     colour_next = rx_data[2:0];
                    if (last_payload) state_next = CHECK;
                end
            end
            CHECK: begin
                if (rx_dv) begin
                    state_next = IDLE;
                    if (rx_data == chk_reg) begin
                        commit_load   = (cmd_reg == CMD_LOAD);
                        commit_colour = (cmd_reg == CMD_COLOUR);
                        clear         = (cmd_reg == CMD_CLEAR);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end
    end

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (state_reg == IDLE || rx_dv || timeout) tmo_cnt_next = '0;
    end

    // Swap looks at the registered pending flag, so a commit landing on the
    // same frame_sync waits for the next boundary.
    assign swap = frame_sync && pending_reg;

    always_comb begin
        pending_next = pending_reg;
        if (swap || pending_clr)     pending_next = 1'b0;
        if (commit_load || clear)    pending_next = 1'b1;
    end

    led_frame_dbuf u_dbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (idx_reg),
        .wr_data (rx_data),
        .clear   (clear),
        .swap    (swap),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    assign rgb           = rgb_reg;
    assign frame_pending = pending_reg;
    assign busy          = (state_reg != IDLE);
    assign err           = err_reg;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: packets, swap timing, errors, timeout.
module tb_led_frame_loader;

    localparam int TMO = 1024;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       frame_sync;
    logic [3:0] rd_col;
    logic [7:0] rd_data;
    logic [2:0] rgb;
    logic       frame_pending;
    logic       busy;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    led_frame_loader #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TMO),
        .RGB_RESET    (3'b101)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_dv         (rx_dv),
        .frame_sync    (frame_sync),
        .rd_col        (rd_col),
        .rd_data       (rd_data),
        .rgb           (rgb),
        .frame_pending (frame_pending),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte strobe; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_dv   = 1'b1;
        tick();
        rx_dv   = 1'b0;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic read_col(input logic [3:0] c, output logic [7:0] d);
        rd_col = c;
        #1;
        d = rd_data;
    endtask

    initial begin
        logic [7:0] d;
        int waited;
        bit seen;

        reset = 1'b1; rx_data = '0; rx_dv = 1'b0; frame_sync = 1'b0; rd_col = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        for (int c = 0; c < 16; c++) begin
            read_col(4'(c), d);
            check($sformatf("reset_col%0d", c), {24'd0, d}, 32'h00);
        end
        check("reset_rgb", {29'd0, rgb}, 32'h5);
        check("reset_pending", {31'd0, frame_pending}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_err", {31'd0, err}, 32'h0);

        // Junk byte in IDLE is ignored silently
        send_byte(8'h42);
        check("junk_err", {31'd0, err}, 32'h0);
        check("junk_busy", {31'd0, busy}, 32'h0);

        // LOAD k*0x11; XOR of payload is 00, so CHK = 01
        send_byte(8'hA5);
        send_byte(8'h01);
        check("load_busy", {31'd0, busy}, 32'h1);
        for (int k = 0; k < 16; k++) send_byte(8'(k * 8'h11));
        send_byte(8'h01);
        check("load_pending", {31'd0, frame_pending}, 32'h1);
        read_col(4'd5, d);
        check("load_no_show", {24'd0, d}, 32'h00);
        pulse_sync();
        read_col(4'd5, d);
        check("swap_col5", {24'd0, d}, 32'h55);
        read_col(4'd15, d);
        check("swap_col15", {24'd0, d}, 32'hFF);
        check("swap_pending", {31'd0, frame_pending}, 32'h0);

        // COLOUR: 02 ^ 03 = 01
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03); send_byte(8'h01);
        check("colour_rgb", {29'd0, rgb}, 32'h3);
        check("colour_err", {31'd0, err}, 32'h0);
        check("colour_pending", {31'd0, frame_pending}, 32'h0);
        // Bad checksum: 02 ^ 06 = 04, send 00
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h06); send_byte(8'h00);
        check("badchk_err", {31'd0, err}, 32'h1);
        check("badchk_rgb", {29'd0, rgb}, 32'h3);
        tick();
        check("err_one_cycle", {31'd0, err}, 32'h0);

        // Unknown command
        send_byte(8'hA5); send_byte(8'h07);
        check("badcmd_err", {31'd0, err}, 32'h1);
        check("badcmd_busy", {31'd0, busy}, 32'h0);
        // Following valid COLOUR: 02 ^ 05 = 07
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05); send_byte(8'h07);
        check("after_badcmd_rgb", {29'd0, rgb}, 32'h5);

        // Timeout during LOAD
        send_byte(8'hA5); send_byte(8'h01);
        for (int k = 0; k < 5; k++) send_byte(8'hEE);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < TMO + 50) begin
            tick();
            waited++;
            if (err) seen = 1'b1;
            else if (!busy) waited = TMO + 50;
        end
        check("tmo_err_seen", {31'd0, seen}, 32'h1);
        check("tmo_cycles", waited, TMO);
        check("tmo_busy", {31'd0, busy}, 32'h0);
        check("tmo_pending", {31'd0, frame_pending}, 32'h0);
        pulse_sync();
        read_col(4'd5, d);
        check("tmo_no_swap", {24'd0, d}, 32'h55);

        // LOAD with CHK strobe coinciding with frame_sync; payload k, CHK = 01
        send_byte(8'hA5); send_byte(8'h01);
        for (int k = 0; k < 16; k++) send_byte(8'(k));
        rx_data = 8'h01; rx_dv = 1'b1; frame_sync = 1'b1;
        tick();
        rx_dv = 1'b0; frame_sync = 1'b0;
        check("coinc_pending", {31'd0, frame_pending}, 32'h1);
        read_col(4'd5, d);
        check("coinc_no_swap", {24'd0, d}, 32'h55);
        pulse_sync();
        read_col(4'd5, d);
        check("coinc_next_swap", {24'd0, d}, 32'h05);
        read_col(4'd12, d);
        check("coinc_col12", {24'd0, d}, 32'h0C);

        // CLEAR then swap shows all zeros
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
        check("clear_pending", {31'd0, frame_pending}, 32'h1);
        pulse_sync();
        for (int c = 0; c < 16; c += 5) begin
            read_col(4'(c), d);
            check($sformatf("clear_col%0d", c), {24'd0, d}, 32'h00);
        end

        // Mid-packet reset clears everything
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h03);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_rgb", {29'd0, rgb}, 32'h5);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_pending", {31'd0, frame_pending}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
